shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter W, default 8: operand/result width, matching the shared barrel shifter.
REQ-002 Parameter SW, default 3: shift-amount width, equal to log2(W).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents a shift operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_din  input  W  operand for requester N.
REQ-008 reqN_shamt  input  SW  shift amount for requester N.
REQ-009 reqN_lr  input  1  1 = left shift, 0 = right shift.
REQ-010 reqN_al  input  1  1 = arithmetic right shift, 0 = logical; ignored on left shifts.
REQ-011 rspN_valid  output  1  result for requester N is available.
REQ-012 rspN_ready  input  1  requester N consumes its result.
REQ-013 rspN_dout  output  W  shift result for requester N.
REQ-014 sh_din, sh_shamt, sh_lr, sh_al  output  W/SW/1/1  operand drive to the external combinational barrel shifter.
REQ-015 sh_dout  input  W  barrel shifter result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 grant  output  1  index of the requester currently owning the shifter.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC and RESP, with IDLE as the reset state.
REQ-019 IDLE with no reqN_valid: remain in IDLE; all ready and rsp_valid outputs low.
REQ-020 IDLE with at least one reqN_valid: select a winner and assert reqN_ready for the winner only, combinationally in the same cycle.
REQ-021 Winner selection: if only one requester is valid, it wins; if both are valid, the requester equal to the priority pointer `prio` wins.
REQ-022 On acceptance, din/shamt/lr/al SHALL be latched into operand registers, `grant` SHALL be set to the winner, and the FSM SHALL go to EXEC.
REQ-023 sh_* outputs SHALL always reflect the operand registers, which hold their value between operations.
REQ-024 EXEC: capture sh_dout into the result register; go to RESP unconditionally after one cycle.
REQ-025 RESP: assert rsp[grant]_valid; rsp[grant]_dout = result register; the other requester's rsp_valid stays low.
REQ-026 rspN_dout SHALL equal the result register for both N; only the valid signal qualifies it.
REQ-027 RESP with rsp[grant]_ready high: set prio = ~grant and return to IDLE.
REQ-028 RESP with rsp[grant]_ready low: hold RESP, with result and valid stable.
REQ-029 Latency: accept in cycle T; rsp_valid high from cycle T+2.
REQ-030 Maximum throughput: one operation per 3 cycles; no new request is accepted before the IDLE state is re-entered.
REQ-031 reqN_valid deasserting while not granted SHALL have no effect; requesters are not required to hold valid.
REQ-032 Shift semantics are the shifter's; shamt=0 SHALL return din unchanged.

Reset
REQ-033 On rst high at a clock edge, the following SHALL be set:
- state = IDLE
- prio = 0
- grant = 0
- operand registers = 0
- result register = 0
- all ready and rsp_valid outputs = 0
- busy = 0
REQ-034 Reset in EXEC or RESP SHALL abort the operation; no response is ever delivered for it.
REQ-035 Reset SHALL override any simultaneous valid or ready input.

Verification
REQ-036 After reset, req0 sends din=0x96, shamt=2, lr=0, al=1 -> req0_ready high at T; rsp0_valid high at T+2 with rsp0_dout=0xE5.
REQ-037 req1 sends din=0x96, shamt=3, lr=1 -> rsp1_dout=0xB0; same request with shamt=4, lr=0, al=0 -> rsp1_dout=0x09.
REQ-038 Both requesters valid continuously with rsp_ready tied high -> grants alternate 0,1,0,1; each requester sees a result every 6 cycles.
REQ-039 Hold rsp0_ready low for 5 cycles in RESP -> rsp0_valid and rsp0_dout stay stable, no reqN_ready asserted; release -> IDLE on the next cycle.
REQ-040 Assert rst during EXEC -> next cycle busy=0 and rsp_valid=0; a subsequent req1 operation is granted (prio=0 but req0 idle) and completes correctly.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one external combinational barrel shifter.
// Accepts one operation at a time: IDLE -> EXEC -> RESP, with round-robin on conflict.
module shift_arbiter #(
   parameter int W  = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [W-1:0]  req0_din,
   input  logic [SW-1:0] req0_shamt,
   input  logic          req0_lr,
   input  logic          req0_al,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [W-1:0]  req1_din,
   input  logic [SW-1:0] req1_shamt,
   input  logic          req1_lr,
   input  logic          req1_al,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [W-1:0]  rsp0_dout,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [W-1:0]  rsp1_dout,
   output logic [W-1:0]  sh_din,
   output logic [SW-1:0] sh_shamt,
   output logic          sh_lr,
   output logic          sh_al,
   input  logic [W-1:0]  sh_dout,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic          prio_reg, prio_next;
   logic          grant_reg, grant_next;
   logic [W-1:0]  op_din_reg;
   logic [SW-1:0] op_shamt_reg;
   logic          op_lr_reg;
   logic          op_al_reg;
   logic [W-1:0]  result_reg;

   logic          accept;
   logic          win;

   // Per-requester views so the datapath can be indexed by requester number.
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    rsp_ready;
   logic [1:0]    rsp_valid;
   logic [W-1:0]  req_din   [2];
   logic [SW-1:0] req_shamt [2];
   logic [1:0]    req_lr;
   logic [1:0]    req_al;

   assign req_valid    = {req1_valid, req0_valid};
   assign rsp_ready    = {rsp1_ready, rsp0_ready};
   assign req_din[0]   = req0_din;
   assign req_din[1]   = req1_din;
   assign req_shamt[0] = req0_shamt;
   assign req_shamt[1] = req1_shamt;
   assign req_lr       = {req1_lr, req0_lr};
   assign req_al       = {req1_al, req0_al};

   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];
   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];

   // Only a genuine conflict consults the priority pointer.
   always_comb begin
      win = 1'b0;
      if (req_valid == 2'b11) begin
         win = prio_reg;
      end else if (req_valid[1]) begin
         win = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      prio_next  = prio_reg;
      grant_next = grant_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               accept     = 1'b1;
               grant_next = win;
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready[grant_reg]) begin
               prio_next  = ~grant_reg;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         // Reset masks the combinational handshake so no transfer is implied.
         assign req_ready[gi] = accept && (win == 1'(gi)) && !rst;
         assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         prio_reg  <= 1'b0;
         grant_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
         grant_reg <= grant_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_din_reg   <= '0;
         op_shamt_reg <= '0;
         op_lr_reg    <= 1'b0;
         op_al_reg    <= 1'b0;
      end else if (accept) begin
         op_din_reg   <= req_din[win];
         op_shamt_reg <= req_shamt[win];
         op_lr_reg    <= req_lr[win];
         op_al_reg    <= req_al[win];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= '0;
      end else if (state_reg == EXEC) begin
         result_reg <= sh_dout;
      end
   end

   assign sh_din    = op_din_reg;
   assign sh_shamt  = op_shamt_reg;
   assign sh_lr     = op_lr_reg;
   assign sh_al     = op_al_reg;
   assign rsp0_dout = result_reg;
   assign rsp1_dout = result_reg;
   assign busy      = (state_reg != IDLE);
   assign grant     = grant_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, hand sequences for reset/hold/alternation,
// and randomized operations checked against an arithmetic reference model.
module tb_shift_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req0_lr, req0_al;
   logic       req1_valid, req1_ready, req1_lr, req1_al;
   logic [7:0] req0_din, req1_din;
   logic [2:0] req0_shamt, req1_shamt;
   logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [7:0] rsp0_dout, rsp1_dout;
   logic [7:0] sh_din, sh_dout;
   logic [2:0] sh_shamt;
   logic       sh_lr, sh_al, busy, grant;

   int tests = 0;
   int fails = 0;
   bit prio_m = 1'b0;

   always #5 clk = ~clk;

   shift_arbiter #(.W(8), .SW(3)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
      .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
      .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dout(rsp0_dout),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dout(rsp1_dout),
      .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
      .sh_dout(sh_dout), .busy(busy), .grant(grant)
   );

   // External barrel shifter.
   always_comb begin
      if (sh_lr)      sh_dout = sh_din << sh_shamt;
      else if (sh_al) sh_dout = $signed(sh_din) >>> sh_shamt;
      else            sh_dout = sh_din >> sh_shamt;
   end

   // Reference result from plain integer arithmetic.
   function automatic logic [7:0] ref_shift(input logic [7:0] din, input int n,
                                            input bit lr, input bit al);
      int d, s, q;
      d = 1 << n;
      if (lr) return 8'((int'(din) * d) % 256);
      if (!al || !din[7]) return 8'(int'(din) / d);
      s = int'(din) - 256;
      q = -((-s + d - 1) / d);
      return 8'(q & 255);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input bit id, input bit v, input logic [7:0] din,
                          input logic [2:0] sh, input bit lr, input bit al);
      if (id == 1'b0) begin
         req0_valid = v; req0_din = din; req0_shamt = sh; req0_lr = lr; req0_al = al;
      end else begin
         req1_valid = v; req1_din = din; req1_shamt = sh; req1_lr = lr; req1_al = al;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_ready1", req1_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      prio_m = 1'b0;
   endtask

   // Single-requester operation: accept at T, result at T+2, optional backpressure.
   task automatic do_op(input bit id, input logic [7:0] din, input logic [2:0] sh,
                        input bit lr, input bit al, input int hold, input logic [7:0] exp);
      logic [7:0] d;
      @(negedge clk);
      set_req(id, 1'b1, din, sh, lr, al);
      #1;
      check("ready_T", id ? req1_ready : req0_ready, 1'b1);
      check("ready_other_T", id ? req0_ready : req1_ready, 1'b0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check("exec_busy", busy, 1'b1);
      check("exec_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      check("exec_sh_din", sh_din, din);
      @(negedge clk);
      #1;
      check("resp_valid", {rsp1_valid, rsp0_valid}, id ? 2'b10 : 2'b01);
      check("resp_grant", grant, id);
      d = id ? rsp1_dout : rsp0_dout;
      check("resp_dout", d, exp);
      for (int h = 0; h < hold; h++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         @(negedge clk);
         #1;
         check("hold_valid", id ? rsp1_valid : rsp0_valid, 1'b1);
         check("hold_dout", id ? rsp1_dout : rsp0_dout, exp);
         check("hold_no_ready", {req1_ready, req0_ready}, 2'b00);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      check("release_idle", busy, 1'b0);
      prio_m = ~id;
      $display("[TB] op req%0d din=%02h sh=%0d lr=%0d al=%0d -> %02h (exp %02h)",
               id, din, sh, lr, al, d, exp);
   endtask

   typedef struct {
      bit         id;
      logic [7:0] din;
      logic [2:0] sh;
      bit         lr;
      bit         al;
      int         hold;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      bit         v0, v1, w, lr0, lr1, al0, al1;
      logic [7:0] d0, d1, e, got;
      logic [2:0] s0, s1;
      int         hold, vsel, ngrant, last0, last1;
      bit         exp_g;

      tbl[0] = '{1'b0, 8'h96, 3'd2, 1'b0, 1'b1, 0, 8'hE5};
      tbl[1] = '{1'b1, 8'h96, 3'd3, 1'b1, 1'b0, 0, 8'hB0};
      tbl[2] = '{1'b1, 8'h96, 3'd4, 1'b0, 1'b0, 0, 8'h09};
      tbl[3] = '{1'b0, 8'h96, 3'd0, 1'b0, 1'b1, 0, 8'h96};
      tbl[4] = '{1'b0, 8'h96, 3'd0, 1'b1, 1'b0, 0, 8'h96};
      tbl[5] = '{1'b1, 8'h7F, 3'd7, 1'b0, 1'b1, 0, 8'h00};
      tbl[6] = '{1'b0, 8'h80, 3'd7, 1'b0, 1'b1, 5, 8'hFF};
      tbl[7] = '{1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, 1, 8'h80};

      rst = 1'b1;
      set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_grant", grant, 1'b0);
      check("reset_ready", {req1_ready, req0_ready}, 2'b00);
      check("reset_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      check("reset_sh", {sh_din, sh_shamt, sh_lr, sh_al}, 32'h0);
      check("reset_dout", rsp0_dout, 8'h00);

      foreach (tbl[i])
         do_op(tbl[i].id, tbl[i].din, tbl[i].sh, tbl[i].lr, tbl[i].al, tbl[i].hold, tbl[i].exp);

      // Reset while in EXEC aborts the operation.
      @(negedge clk);
      set_req(1'b0, 1'b1, 8'h5A, 3'd1, 1'b1, 1'b0);
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      prio_m = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      check("abort_grant", grant, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      end
      do_op(1'b1, 8'h96, 3'd3, 1'b1, 1'b0, 0, 8'hB0);

      // Both requesters always valid, responses always consumed: strict alternation.
      do_reset();
      @(negedge clk);
      set_req(1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1);
      set_req(1'b1, 1'b1, 8'h81, 3'd1, 1'b1, 1'b0);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      ngrant = 0; last0 = -1; last1 = -1; exp_g = 1'b0;
      for (int c = 0; c < 18; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            check("alt_grant", {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
            if (exp_g) begin
               if (last1 >= 0) check("alt_period1", c - last1, 6);
               last1 = c;
            end else begin
               if (last0 >= 0) check("alt_period0", c - last0, 6);
               last0 = c;
            end
            $display("[TB] alt cycle %0d grant req%0d", c, req1_ready);
            exp_g = ~exp_g;
            ngrant++;
         end
         @(negedge clk);
      end
      check("alt_count", ngrant, 6);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      do_reset();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         vsel = $urandom_range(1, 3);
         v0 = vsel[0]; v1 = vsel[1];
         d0 = 8'($urandom); d1 = 8'($urandom);
         s0 = 3'($urandom); s1 = 3'($urandom);
         lr0 = 1'($urandom); lr1 = 1'($urandom);
         al0 = 1'($urandom); al1 = 1'($urandom);
         w = (v0 && v1) ? prio_m : v1;
         e = w ? ref_shift(d1, int'(s1), lr1, al1) : ref_shift(d0, int'(s0), lr0, al0);
         @(negedge clk);
         set_req(1'b0, v0, d0, s0, lr0, al0);
         set_req(1'b1, v1, d1, s1, lr1, al1);
         #1;
         check("rnd_ready", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
         @(negedge clk);
         req0_valid = 1'($urandom); req1_valid = 1'($urandom);
         #1;
         check("rnd_exec_ready", {req1_ready, req0_ready}, 2'b00);
         @(negedge clk);
         #1;
         check("rnd_rsp_valid", {rsp1_valid, rsp0_valid}, w ? 2'b10 : 2'b01);
         got = w ? rsp1_dout : rsp0_dout;
         check("rnd_dout", got, e);
         hold = $urandom_range(0, 2);
         for (int h = 0; h < hold; h++) begin
            if (w) rsp0_ready = 1'($urandom); else rsp1_ready = 1'($urandom);
            @(negedge clk);
            #1;
            check("rnd_hold", {rsp1_valid, rsp0_valid, rsp0_dout}, {w, ~w, e});
         end
         if (w) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
         @(negedge clk);
         req0_valid = 1'b0; req1_valid = 1'b0;
         rsp0_ready = 1'b0; rsp1_ready = 1'b0;
         #1;
         check("rnd_idle", busy, 1'b0);
         prio_m = ~w;
         $display("[TB] rnd %0d valid=%0d%0d grant req%0d -> %02h (exp %02h)",
                  n, v1, v0, w, got, e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
